// File: rtl/bus_cycle_master.sv
// Single-beat read/write requester for an 8088-style multiplexed bus.
// It drives ALE, active-low RD/WR, A[19:8], the shared AD[7:0] bus and a windowed chip select.
module bus_cycle_master #(
    parameter int unsigned STROBE_CYCLES = 2,
    parameter logic [19:0] DEV_BASE      = 20'h00000,
    parameter logic [19:0] DEV_MASK      = 20'h00000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [19:0] addr,
    input  logic [7:0]  wdata,
    input  logic        ready,
    output logic        busy,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        ALE,
    output logic        RD,
    output logic        WR,
    output logic        CS,
    output logic [11:0] A,
    inout  wire  [7:0]  AD
);

    typedef enum logic [5:0] {
        S_TI = 6'b000001,
        S_T1 = 6'b000010,
        S_T2 = 6'b000100,
        S_T3 = 6'b001000,
        S_T4 = 6'b010000,
        S_TR = 6'b100000
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [19:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rcap;
    logic        r_busy, r_ack, r_ale, r_rd, r_wr, r_cs, r_ad_oe;
    logic [7:0]  r_rdata, r_ad_out;
    logic [11:0] r_a;

    logic        w_accept, w_we, w_hit, w_addr_phase, w_in_cycle;
    logic [19:0] w_addr;
    logic [7:0]  w_wdata;
    logic        w_busy_d, w_ack_d, w_ale_d, w_rd_d, w_wr_d, w_cs_d, w_ad_oe_d;
    logic [11:0] w_a_d;
    logic [7:0]  w_ad_out_d;

    // Outputs are registered from the next state, so in the accept cycle the
    // transaction attributes come straight from the request inputs.
    assign w_accept = (r_state == S_TI) && req;
    assign w_we     = w_accept ? we    : r_we;
    assign w_addr   = w_accept ? addr  : r_addr;
    assign w_wdata  = w_accept ? wdata : r_wdata;
    assign w_hit    = ((w_addr & DEV_MASK) == (DEV_BASE & DEV_MASK));

    always_comb begin
        w_next       = r_state;
        w_addr_phase = 1'b0;
        w_in_cycle   = 1'b0;
        w_busy_d     = 1'b0;
        w_ack_d      = 1'b0;
        w_ale_d      = 1'b0;
        w_rd_d       = 1'b1;
        w_wr_d       = 1'b1;
        w_cs_d       = 1'b0;
        w_a_d        = '0;
        w_ad_oe_d    = 1'b0;
        w_ad_out_d   = '0;

        case (r_state)
            S_TI:    if (req) w_next = S_T1;
            S_T1:    w_next = S_T2;
            S_T2:    w_next = S_T3;
            S_T3:    if ((r_cnt == 4'd0) && ready) w_next = S_T4;
            S_T4:    w_next = S_TR;
            S_TR:    w_next = S_TI;
            default: w_next = S_TI;
        endcase

        w_addr_phase = (w_next == S_T1) || (w_next == S_T2);
        w_in_cycle   = w_addr_phase || (w_next == S_T3) || (w_next == S_T4);
        w_busy_d     = (w_next != S_TI);
        w_ack_d      = (w_next == S_TR);
        w_ale_d      = (w_next == S_T1);
        w_rd_d       = !((w_next == S_T3) && !w_we);
        w_wr_d       = !((w_next == S_T3) && w_we);
        w_cs_d       = w_in_cycle && w_hit;
        w_a_d        = w_in_cycle ? w_addr[19:8] : 12'h000;
        // Write data stays on AD through T4: the slave commits on the WR rising edge.
        w_ad_oe_d    = w_addr_phase || (w_we && ((w_next == S_T3) || (w_next == S_T4)));
        w_ad_out_d   = w_addr_phase ? w_addr[7:0] : w_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_TI;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rcap   <= '0;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_ale    <= 1'b0;
            r_rd     <= 1'b1;
            r_wr     <= 1'b1;
            r_cs     <= 1'b0;
            r_a      <= '0;
            r_ad_oe  <= 1'b0;
            r_ad_out <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_we    <= we;
                r_addr  <= addr;
                r_wdata <= wdata;
            end
            if (r_state == S_T2) begin
                r_cnt <= CNT_LOAD;
            end else if ((r_state == S_T3) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if ((r_state == S_T3) && (w_next == S_T4) && !r_we) begin
                r_rcap <= AD;
            end
            if ((r_state == S_T4) && !r_we) begin
                r_rdata <= r_rcap;
            end
            r_busy   <= w_busy_d;
            r_ack    <= w_ack_d;
            r_ale    <= w_ale_d;
            r_rd     <= w_rd_d;
            r_wr     <= w_wr_d;
            r_cs     <= w_cs_d;
            r_a      <= w_a_d;
            r_ad_oe  <= w_ad_oe_d;
            r_ad_out <= w_ad_out_d;
        end
    end

    assign AD    = r_ad_oe ? r_ad_out : 8'bz;
    assign busy  = r_busy;
    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign ALE   = r_ale;
    assign RD    = r_rd;
    assign WR    = r_wr;
    assign CS    = r_cs;
    assign A     = r_a;

endmodule

// File: tb/tb_bus_cycle_master.sv
// Bench for bus_cycle_master: a byte-wide slave on the main bus, a decode-window instance,
// and an abstract memory/timing model that predicts each cycle's waveform.
module tb_bus_cycle_master;

    localparam int S = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic        ready = 1'b1;
    logic        sel   = 1'b0;
    logic [19:0] addr  = '0;
    logic [7:0]  wdata = '0;
    logic        req_a, req_b;

    wire  [7:0]  AD, AD2;
    logic        busy, ack, ALE, RD, WR, CS;
    logic        busy2, ack2, ALE2, RD2, WR2, CS2;
    logic [7:0]  rdata, rdata2;
    logic [11:0] A, A2;

    logic        m_busy, m_ack, m_ALE, m_RD, m_WR, m_CS;
    logic [7:0]  m_rdata, m_AD;
    logic [11:0] m_A;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mmem [logic [19:0]];
    logic [7:0]  last_rd [0:1];
    logic [19:0] pool [0:7];

    always #5 clock = ~clock;

    assign req_a = req & ~sel;
    assign req_b = req & sel;

    bus_cycle_master #(.STROBE_CYCLES(S)) dut (
        .clock(clock), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .busy(busy), .ack(ack), .rdata(rdata), .ALE(ALE), .RD(RD),
        .WR(WR), .CS(CS), .A(A), .AD(AD)
    );

    bus_cycle_master #(.STROBE_CYCLES(S), .DEV_BASE(20'h80000), .DEV_MASK(20'hF0000)) dut_dec (
        .clock(clock), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .busy(busy2), .ack(ack2), .rdata(rdata2), .ALE(ALE2), .RD(RD2),
        .WR(WR2), .CS(CS2), .A(A2), .AD(AD2)
    );

    assign m_busy  = sel ? busy2  : busy;
    assign m_ack   = sel ? ack2   : ack;
    assign m_ALE   = sel ? ALE2   : ALE;
    assign m_RD    = sel ? RD2    : RD;
    assign m_WR    = sel ? WR2    : WR;
    assign m_CS    = sel ? CS2    : CS;
    assign m_A     = sel ? A2     : A;
    assign m_rdata = sel ? rdata2 : rdata;
    assign m_AD    = sel ? AD2    : AD;

    // Slave on the main bus: latches the address while ALE is high, drives AD while RD is low,
    // and commits a write on the first edge that sees WR high again.
    logic [7:0]  smem [0:255];
    logic [11:0] stag [0:255];
    logic [7:0]  s_ptr = '0;
    logic [11:0] s_hi  = '0;
    logic        s_wr_q = 1'b1;

    always @(posedge clock) begin
        if (ALE === 1'b1) begin
            s_ptr <= AD;
            s_hi  <= A;
        end
        s_wr_q <= WR;
        if ((WR === 1'b1) && (s_wr_q === 1'b0) && !$isunknown(AD)) begin
            smem[s_ptr] <= AD;
            stag[s_ptr] <= s_hi;
        end
    end

    assign AD = (RD === 1'b0) ? smem[s_ptr] : 8'bz;

    function automatic logic [7:0] norm_ad(input logic [7:0] v);
        return $isunknown(v) ? 8'h00 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request, sampled every falling edge; the waveform is then compared to what
    // the bus rules predict for this access (index 1 = first clock after the accept edge).
    task automatic run_txn(input logic t_we, input logic [19:0] t_addr, input logic [7:0] t_wd,
                           input int waits, input bit poke);
        logic [31:0] v_ale, v_rdl, v_wrl, v_cs, v_ack, v_busy;
        logic [31:0] e_strb, e_cs, e_busy;
        logic [7:0]  rec_ad    [0:31];
        logic [11:0] rec_a     [0:31];
        logic [7:0]  rec_rdata [0:31];
        logic [7:0]  exp_rd, e;
        logic        hit;
        int          t4, tr, len, nlow;

        t4  = 2 + S + waits + 1;
        tr  = t4 + 1;
        len = t4 + 4;
        hit = sel ? ((t_addr & 20'hF0000) == 20'h80000) : 1'b1;
        exp_rd = t_we ? 8'h00 : mmem[t_addr];
        v_ale = '0; v_rdl = '0; v_wrl = '0; v_cs = '0; v_ack = '0; v_busy = '0;
        nlow = 0;

        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wd; ready = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clock);
            v_ale[k]     = m_ALE;
            v_rdl[k]     = !m_RD;
            v_wrl[k]     = !m_WR;
            v_cs[k]      = m_CS;
            v_ack[k]     = m_ack;
            v_busy[k]    = m_busy;
            rec_ad[k]    = m_AD;
            rec_a[k]     = m_A;
            rec_rdata[k] = m_rdata;
            if ((m_RD === 1'b0) || (m_WR === 1'b0)) nlow++;
            ready = !((nlow >= S) && (nlow < S + waits));
            req   = poke && (k == 2);
        end
        req = 1'b0; ready = 1'b1;

        e_strb = ((32'd1 << (S + waits)) - 32'd1) << 3;
        e_cs   = hit ? (((32'd1 << (t4 + 1)) - 32'd1) & ~32'd1) : 32'd0;
        e_busy = ((32'd1 << (tr + 1)) - 32'd1) & ~32'd1;
        check("ALE_wave", v_ale, 32'd1 << 1);
        check("RD_wave", v_rdl, t_we ? 32'd0 : e_strb);
        check("WR_wave", v_wrl, t_we ? e_strb : 32'd0);
        check("CS_wave", v_cs, e_cs);
        check("ack_wave", v_ack, 32'd1 << tr);
        check("busy_wave", v_busy, e_busy);

        for (int k = 1; k <= len; k++) begin
            if (k <= 2)                 e = t_addr[7:0];
            else if (k <= t4 && t_we)   e = t_wd;
            else if (k < t4 && !t_we)   e = exp_rd;
            else                        e = 8'h00;
            if (k <= 2 || (k < t4) || (k == t4 && t_we))
                check($sformatf("AD[%0d]", k), rec_ad[k], e);
            else
                check($sformatf("AD_released[%0d]", k), norm_ad(rec_ad[k]), e);
            check($sformatf("A[%0d]", k), rec_a[k], (k <= t4) ? t_addr[19:8] : 12'h000);
        end

        if (t_we) begin
            check("rdata_kept", rec_rdata[tr], last_rd[sel]);
            if (!sel) mmem[t_addr] = t_wd;
        end else begin
            check("rdata_ack", rec_rdata[tr], exp_rd);
            last_rd[sel] = exp_rd;
            check("rdata_held", rec_rdata[len], exp_rd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;

        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_ALE", m_ALE, 0);
        check("rst_RD", m_RD, 1);
        check("rst_WR", m_WR, 1);
        check("rst_CS", m_CS, 0);
        check("rst_A", m_A, 0);
        check("rst_AD", norm_ad(m_AD), 0);
        check("rst_busy", m_busy, 0);
        check("rst_ack", m_ack, 0);
        check("rst_rdata", m_rdata, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        run_txn(1'b1, 20'hA53C1, 8'h5E, 0, 1'b0);
        check("slave_holds", {stag[8'hC1], smem[8'hC1]}, {12'hA53, 8'h5E});
        run_txn(1'b0, 20'hA53C1, 8'h81, 0, 1'b0);
        run_txn(1'b0, 20'hA53C1, 8'h81, 3, 1'b0);
        run_txn(1'b0, 20'hA53C1, 8'h81, 0, 1'b1);

        // Abort a write in the middle of its strobe.
        req = 1'b1; we = 1'b1; addr = 20'h12345; wdata = 8'h77; ready = 1'b1;
        @(posedge clock);
        #1 req = 1'b0;
        for (int k = 0; k < 8 && m_WR !== 1'b0; k++) @(negedge clock);
        check("abort_wr_low", m_WR, 0);
        #2 reset = 1'b0;
        #1;
        check("abort_WR", m_WR, 1);
        check("abort_RD", m_RD, 1);
        check("abort_AD", norm_ad(m_AD), 0);
        check("abort_busy", m_busy, 0);
        check("abort_CS", m_CS, 0);
        check("abort_A", m_A, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("abort_no_ack", m_ack, 0);
        end
        reset = 1'b1;
        last_rd[0] = 8'h00;
        @(negedge clock);
        run_txn(1'b0, 20'hA53C1, 8'h3B, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            pool[i] = {12'($urandom), 8'h10 + 8'(i) * 8'h11};
            run_txn(1'b1, pool[i], 8'($urandom) | 8'h01, $urandom_range(0, 3), 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            run_txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                    8'($urandom) | 8'h01, $urandom_range(0, 3), 1'b0);
        end

        sel = 1'b1;
        @(negedge clock);
        run_txn(1'b1, 20'h81234, 8'hC3, 0, 1'b0);
        run_txn(1'b1, 20'h11234, 8'h96, 1, 1'b0);
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
